spike_mac_accum: RTL and testbench

//  Parametrised multi-beat spike-gated MAC. Each beat carries LANES 1-bit pixels/spikes and LANES signed
//  Q1.(WIDTH-1) weights. Lane product = weight if pixel=1, else 0. Per-beat partial sums are accumulated

---
 rtl/spike_mac_accum.sv | 204 ++++++++++++++++++++
 tb/tb_spike_mac_accum.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_mac_accum.sv
// ---------------------------------------------------------------------------
// spike_mac_accum
//   Multi-beat, spike-gated multiply-accumulate. Each accepted beat carries
//   LANES pixel/spike bits and LANES signed Q1.(WIDTH-1) weights. A lane
//   contributes its weight when its pixel bit is set and zero otherwise. The
//   per-beat partial sums are accumulated into one saturating signed neuron
//   sum. A dot product spans a variable number of beats and ends on in_last.
//   It is force-terminated after MAX_BEATS beats.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   beat valid
//   in_ready   beat accepted when in_valid & in_ready
//   in_last    final beat of the current dot product
//   p          pixel/spike bits, lane i = p[i]
//   w          weights, lane i = w[WIDTH*i +: WIDTH], signed
//   out_valid  result valid
//   out_ready  result consumed when out_valid & out_ready
//   sum        signed accumulated sum, scale 2^-(WIDTH-1)
//   sat        saturation occurred during this dot product
//   len_err    MAX_BEATS reached without in_last
//   beats      number of beats in the reported sum
// ---------------------------------------------------------------------------
module spike_mac_accum #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 5,
    parameter int ACC_W     = 16,
    parameter int MAX_BEATS = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic [LANES-1:0]               p,
    input  logic [WIDTH*LANES-1:0]         w,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [ACC_W-1:0]        sum,
    output logic                           sat,
    output logic                           len_err,
    output logic [$clog2(MAX_BEATS+1)-1:0] beats
);

    // Partial width: enough headroom to add LANES full-scale weights exactly.
    localparam int PW = WIDTH + $clog2(LANES);
    // One guard bit above the accumulator catches overflow of acc + partial.
    localparam int SW = ACC_W + 1;
    localparam int BW = $clog2(MAX_BEATS + 1);

    localparam logic [BW-1:0]           LAST_BEAT = BW'(MAX_BEATS);
    localparam logic signed [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_FLUSH,
        S_OUT
    } state_t;

    // The extended sum overflowed the accumulator range when the guard bit
    // disagrees with the accumulator sign bit.
    function automatic logic clip_hit(input logic signed [SW-1:0] x);
        return x[SW-1] ^ x[SW-2];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_clip(input logic signed [SW-1:0] x);
        if (!clip_hit(x)) begin
            return x[ACC_W-1:0];
        end else if (x[SW-1]) begin
            return ACC_MIN;
        end else begin
            return ACC_MAX;
        end
    endfunction

    state_t               state;
    logic [BW-1:0]        cnt;
    logic [BW-1:0]        cnt_next;
    logic                 len_hit;
    logic                 accept;
    logic                 beat_limit;
    logic                 last_p0;
    logic                 hs;

    logic signed [WIDTH-1:0] lane_w;
    logic signed [PW-1:0]    partial_p0;

    logic signed [PW-1:0]    part_p1;
    logic                    last_p1;
    logic                    vld_p1;

    logic signed [ACC_W-1:0] acc;
    logic                    sat_acc;
    logic                    done_p2;
    logic signed [SW-1:0]    acc_sum;

    assign accept     = in_valid & in_ready;
    assign hs         = out_valid & out_ready;
    assign cnt_next   = cnt + BW'(1);
    // The MAX_BEATS-th beat closes the dot product even without in_last.
    assign beat_limit = (cnt_next == LAST_BEAT);
    assign last_p0    = in_last | beat_limit;

    // ---- Stage 0: gated lane sum (combinational) ----
    always_comb begin
        partial_p0 = '0;
        lane_w     = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_w = w[WIDTH*i +: WIDTH];
            if (p[i]) begin
                partial_p0 = partial_p0 + PW'(lane_w);
            end
        end
    end

    assign acc_sum = SW'(acc) + SW'(part_p1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            part_p1 <= '0;
            last_p1 <= 1'b0;
            vld_p1  <= 1'b0;
            acc     <= '0;
            sat_acc <= 1'b0;
            done_p2 <= 1'b0;
        end else begin
            // ---- Stage 1: register partial sum with its last flag ----
            vld_p1  <= accept;
            last_p1 <= accept & last_p0;
            if (accept) begin
                part_p1 <= partial_p0;
            end

            // ---- Stage 2: saturating accumulate ----
            // done_p2 marks that acc now holds the final partial.
            done_p2 <= vld_p1 & last_p1;
            if (hs) begin
                acc     <= '0;
                sat_acc <= 1'b0;
            end else if (vld_p1) begin
                acc     <= sat_clip(acc_sum);
                sat_acc <= sat_acc | clip_hit(acc_sum);
            end
        end
    end

    // Control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
            len_hit   <= 1'b0;
            sum       <= '0;
            sat       <= 1'b0;
            len_err   <= 1'b0;
            beats     <= '0;
        end else begin
            case (state)
                S_IDLE, S_ACC: begin
                    if (accept) begin
                        cnt <= cnt_next;
                        if (beat_limit && !in_last) begin
                            len_hit <= 1'b1;
                        end
                        if (last_p0) begin
                            state    <= S_FLUSH;
                            in_ready <= 1'b0;
                        end else begin
                            state <= S_ACC;
                        end
                    end
                end
                S_FLUSH: begin
                    if (done_p2) begin
                        state     <= S_OUT;
                        out_valid <= 1'b1;
                        sum       <= acc;
                        sat       <= sat_acc;
                        len_err   <= len_hit;
                        beats     <= cnt;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        cnt       <= '0;
                        len_hit   <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_mac_accum.sv
// ---------------------------------------------------------------------------
// tb_spike_mac_accum
//   Scoreboard bench for spike_mac_accum. The driver pushes the expected
//   result of each dot product when its closing beat is accepted; a monitor
//   pops and compares whenever the DUT completes an output handshake.
// ---------------------------------------------------------------------------
module tb_spike_mac_accum;

    localparam int WIDTH     = 8;
    localparam int LANES     = 5;
    localparam int ACC_W     = 12;
    localparam int MAX_BEATS = 4;
    localparam int BW        = $clog2(MAX_BEATS + 1);
    localparam int AMAX      = (1 << (ACC_W - 1)) - 1;
    localparam int AMIN      = -(1 << (ACC_W - 1));

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic                    in_last = 1'b0;
    logic [LANES-1:0]        p = '0;
    logic [WIDTH*LANES-1:0]  w = '0;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] sum;
    logic                    sat;
    logic                    len_err;
    logic [BW-1:0]           beats;

    logic man_ready = 1'b0;
    logic rand_bp   = 1'b0;
    logic rnd_ready = 1'b0;

    assign out_ready = rand_bp ? rnd_ready : man_ready;

    spike_mac_accum #(
        .WIDTH    (WIDTH),
        .LANES    (LANES),
        .ACC_W    (ACC_W),
        .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .p        (p),
        .w        (w),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .sat      (sat),
        .len_err  (len_err),
        .beats    (beats)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 2) != 0);
    end

    typedef struct {
        int s;
        bit st;
        bit le;
        int nb;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: running dot product as plain integers.
    int m_acc = 0;
    int m_cnt = 0;
    bit m_sat = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_beat(input logic [LANES-1:0] pv, input logic [WIDTH*LANES-1:0] wv,
                              input bit last);
        int   ps = 0;
        byte  b;
        exp_t e;
        for (int i = 0; i < LANES; i++) begin
            if (pv[i]) begin
                b = wv[WIDTH*i +: WIDTH];
                ps += b;
            end
        end
        m_acc += ps;
        if (m_acc > AMAX) begin
            m_acc = AMAX;
            m_sat = 1;
        end else if (m_acc < AMIN) begin
            m_acc = AMIN;
            m_sat = 1;
        end
        m_cnt++;
        if (last || m_cnt == MAX_BEATS) begin
            e.s  = m_acc;
            e.st = m_sat;
            e.le = !last;
            e.nb = m_cnt;
            sb.push_back(e);
            m_acc = 0;
            m_sat = 0;
            m_cnt = 0;
        end
    endtask

    // Present one beat until accepted; waited = cycles spent with in_ready=0.
    task automatic send_beat(input logic [LANES-1:0] pv, input logic [WIDTH*LANES-1:0] wv,
                             input bit last, output int waited);
        bit ok;
        bit done;
        waited   = 0;
        ok       = 0;
        done     = 0;
        in_valid = 1'b1;
        p        = pv;
        w        = wv;
        in_last  = last;
        while (!done) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) begin
                done = 1;
            end else begin
                waited++;
                if (waited > 100) begin
                    checks++;
                    failures++;
                    $display("FAIL accept_timeout waited=%0d required=accept", waited);
                    done = 1;
                end
            end
        end
        if (ok) model_beat(pv, wv, last);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_out_valid", int'(out_valid), 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    // Monitor: compare every completed output handshake against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            check("in_ready_in_out", int'(in_ready), 0);
            if (out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out sum=%0d required=no_output", sum);
                end else begin
                    e = sb.pop_front();
                    check("out_sum", int'(sum), e.s);
                    check("out_sat", int'(sat), int'(e.st));
                    check("out_len_err", int'(len_err), int'(e.le));
                    check("out_beats", int'(beats), e.nb);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH*LANES-1:0] t1_w;
        logic [WIDTH*LANES-1:0] all_max;
        logic [WIDTH*LANES-1:0] all_min;
        logic [WIDTH*LANES-1:0] wv;
        logic [LANES-1:0]       pv;
        logic [63:0]            r64;
        int                     wt;
        int                     n;
        int                     nb;
        bit                     give;
        bit                     lst;

        t1_w    = {8'h10, 8'h80, 8'h60, 8'hE0, 8'h40};
        all_max = {LANES{8'h7F}};
        all_min = {LANES{8'h80}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_beats", int'(beats), 0);
        check("rst_sat", int'(sat), 0);
        check("rst_len_err", int'(len_err), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);

        // Single-beat dot product and its latency
        man_ready = 1'b0;
        send_beat(5'b11101, t1_w, 1'b1, wt);
        check("t1_lat_k", int'(out_valid), 0);
        @(posedge clk);
        #1;
        check("t1_lat_k1", int'(out_valid), 0);
        @(posedge clk);
        #1;
        check("t1_lat_k2", int'(out_valid), 1);
        check("t1_sum", int'(sum), 48);
        check("t1_beats", int'(beats), 1);
        man_ready = 1'b1;
        drain();

        // Three back-to-back beats
        for (int b = 0; b < 3; b++) begin
            send_beat(5'b11111, all_max, (b == 2), wt);
            check("t2_no_wait", wt, 0);
        end
        drain();

        // Positive and negative saturation
        for (int b = 0; b < 4; b++) send_beat(5'b11111, all_max, (b == 3), wt);
        drain();
        for (int b = 0; b < 4; b++) send_beat(5'b11111, all_min, (b == 3), wt);
        drain();

        // Backpressure in OUT, then a fresh dot product after saturation
        man_ready = 1'b0;
        for (int b = 0; b < 4; b++) send_beat(5'b11111, all_max, (b == 3), wt);
        wait_out();
        check("t4_sb_has_entry", int'(sb.size() > 0), 1);
        for (int c = 0; c < 5; c++) begin
            if (sb.size() > 0) begin
                check("t4_sum_hold", int'(sum), sb[0].s);
                check("t4_beats_hold", int'(beats), sb[0].nb);
            end
            check("t4_in_ready_low", int'(in_ready), 0);
            check("t4_out_valid_hold", int'(out_valid), 1);
            @(posedge clk);
            #1;
        end
        man_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_idle_out_valid", int'(out_valid), 0);
        check("t4_idle_in_ready", int'(in_ready), 1);
        send_beat(5'b00001, {32'h0, 8'h05}, 1'b1, wt);
        drain();

        // Length limit with a stall inside the dot product
        r64 = {$urandom, $urandom};
        send_beat(5'($urandom), r64[WIDTH*LANES-1:0], 1'b0, wt);
        r64 = {$urandom, $urandom};
        send_beat(5'($urandom), r64[WIDTH*LANES-1:0], 1'b0, wt);
        idle(3);
        r64 = {$urandom, $urandom};
        send_beat(5'($urandom), r64[WIDTH*LANES-1:0], 1'b0, wt);
        r64 = {$urandom, $urandom};
        send_beat(5'($urandom), r64[WIDTH*LANES-1:0], 1'b0, wt);
        check("t5_forced_flush", int'(in_ready), 0);
        drain();

        // Reset in the middle of a dot product
        send_beat(5'b11111, all_max, 1'b0, wt);
        send_beat(5'b11111, all_max, 1'b0, wt);
        rst   = 1'b1;
        m_acc = 0;
        m_cnt = 0;
        m_sat = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("t6_no_output", int'(out_valid), 0);
            @(posedge clk);
            #1;
        end
        check("t6_in_ready", int'(in_ready), 1);
        send_beat(5'b11101, t1_w, 1'b1, wt);
        drain();

        // Randomized dot products with random stalls and backpressure
        rand_bp = 1'b1;
        for (int d = 0; d < 40; d++) begin
            n    = $urandom_range(1, MAX_BEATS);
            give = ($urandom_range(0, 3) != 0);
            nb   = give ? n : MAX_BEATS;
            for (int b = 0; b < nb; b++) begin
                pv = 5'($urandom);
                case ($urandom_range(0, 3))
                    0: wv = all_max;
                    1: wv = all_min;
                    default: begin
                        r64 = {$urandom, $urandom};
                        wv  = r64[WIDTH*LANES-1:0];
                    end
                endcase
                lst = give && (b == nb - 1);
                send_beat(pv, wv, lst, wt);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        drain();
        rand_bp = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
